rv_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit; the multi-cycle counterpart of the single-cycle ALU.

---
 rtl/rv_muldiv_if.sv | 26 ++
 rtl/rv_muldiv.sv | 172 +++++++++++++++++
 tb/tb_rv_muldiv.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rv_muldiv_if.sv
// Request/response channel of the iterative RV32M multiply/divide unit.
// master = core side, slave = the unit itself.
interface rv_muldiv_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            kill;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output kill, req_valid, funct3, operand_a, operand_b, resp_ready,
        input  req_ready, resp_valid, result, busy
    );

    modport slave (
        input  kill, req_valid, funct3, operand_a, operand_b, resp_ready,
        output req_ready, resp_valid, result, busy
    );
endinterface

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, XLEN iterations.
// Define RVSIMPLE_MULDIV_FAST_MUL_EN to resolve MUL* in one cycle with a 33x33 signed multiplier.
module rv_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    rv_muldiv_if.slave  bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opb;
    logic [2:0]      op_f3;
    logic            neg_res;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic            busy_q;
    logic [XLEN-1:0] result_q;

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.busy       = busy_q;
    assign bus.result     = result_q;

    // Accept-side decode: signedness, magnitudes and special cases.
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special, neg_acc;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                   (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        b_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        a_neg    = a_signed && bus.operand_a[XLEN-1];
        b_neg    = b_signed && bus.operand_b[XLEN-1];
        a_mag    = a_neg ? -bus.operand_a : bus.operand_a;
        b_mag    = b_neg ? -bus.operand_b : bus.operand_b;
        div_zero = bus.funct3[2] && (bus.operand_b == '0);
        div_ovf  = ((bus.funct3 == 3'd4) || (bus.funct3 == 3'd6)) &&
                   (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.operand_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = bus.funct3[1] ? bus.operand_a : '1;
        else
            special_res = bus.funct3[1] ? '0 : bus.operand_a;
        // REM takes the dividend's sign; quotient and product take the XOR.
        neg_acc  = (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
    end

`ifdef RVSIMPLE_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_prod;
    logic [XLEN-1:0]          fast_res;

    always_comb begin
        fast_a    = {a_signed && bus.operand_a[XLEN-1], bus.operand_a};
        fast_b    = {b_signed && bus.operand_b[XLEN-1], bus.operand_b};
        fast_prod = fast_a * fast_b;
        fast_res  = (bus.funct3 == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // One iteration step for each algorithm, plus the final sign fix-up.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ok;
    logic [XLEN-1:0]   div_sub;
    logic [XLEN-1:0]   hi_nx, lo_nx;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   div_sel, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc, lo[XLEN-1]};
        div_ok    = div_shift >= {1'b0, opb};
        div_sub   = div_shift[XLEN-1:0] - opb;
        if (op_f3[2]) begin
            hi_nx = div_ok ? div_sub : div_shift[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], div_ok};
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod    = {hi_nx, lo_nx};
        prod_s  = neg_res ? -prod : prod;
        div_sel = op_f3[1] ? hi_nx : lo_nx;
        if (op_f3[2])
            final_res = neg_res ? -div_sel : div_sel;
        else if (op_f3 == 3'd0)
            final_res = prod_s[XLEN-1:0];
        else
            final_res = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            count        <= '0;
            acc          <= '0;
            lo           <= '0;
            opb          <= '0;
            op_f3        <= '0;
            neg_res      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= '0;
        end else if (bus.kill) begin
            state        <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_f3       <= bus.funct3;
                        neg_res     <= neg_acc;
                        count       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (special) begin
                            result_q     <= special_res;
                            resp_valid_q <= 1'b1;
                            state        <= S_DONE;
                        end
`ifdef RVSIMPLE_MULDIV_FAST_MUL_EN
                        else if (!bus.funct3[2]) begin
                            result_q     <= fast_res;
                            resp_valid_q <= 1'b1;
                            state        <= S_DONE;
                        end
`endif
                        else begin
                            // lo holds the value consumed bit by bit: dividend or multiplier.
                            acc   <= '0;
                            lo    <= bus.funct3[2] ? a_mag : b_mag;
                            opb   <= bus.funct3[2] ? b_mag : a_mag;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc   <= hi_nx;
                    lo    <= lo_nx;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN-1)) begin
                        result_q     <= final_res;
                        resp_valid_q <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_muldiv.sv
// Directed self-checking bench for rv_muldiv: arithmetic, special cases, backpressure, kill, reset.
module tb_rv_muldiv;
`ifdef RVSIMPLE_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    rv_muldiv_if #(.XLEN(32)) bus ();

    rv_muldiv #(.XLEN(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.funct3    = f;
        bus.operand_a = a;
        bus.operand_b = b;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clock);
        chk({tag, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        drive_req(f, a, b);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".result"}, bus.result, exp);
        bus.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;
        chk({tag, ".idle"}, {29'd0, bus.busy, bus.resp_valid, bus.req_ready}, 32'b001);
    endtask

    initial begin
        int  lat;
        logic seen;
        reset_n        = 1'b0;
        bus.kill       = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.funct3     = 3'd0;
        bus.operand_a  = '0;
        bus.operand_b  = '0;
        #12;
        chk("rst.req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst.busy",       {31'd0, bus.busy},       32'd0);
        chk("rst.result",     bus.result,              32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("mul_7_m3",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu_min",    3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("mul_m1_m1",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         MUL_LAT);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_m1_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         MUL_LAT);
        run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_100_7",   3'd5, 32'd100,       32'd7,         32'd14,        DIV_LAT);
        run_op("remu_100_7",   3'd7, 32'd100,       32'd7,         32'd2,         DIV_LAT);
        run_op("div_7_m2",     3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_7_m2",     3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT);
        run_op("divu_by0",     3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
        run_op("rem_by0",      3'd6, 32'd5,         32'd0,         32'd5,         0);
        run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

        // Backpressure in DONE, with a competing request held on the channel.
        @(negedge clock);
        drive_req(3'd5, 32'd100, 32'd7);
        @(posedge clock); #1;
        drive_req(3'd5, 32'd5, 32'd0);
        wait_resp(lat);
        chk("hold.latency", lat, DIV_LAT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("hold.result", bus.result, 32'd14);
            chk("hold.flags", {29'd0, bus.busy, bus.resp_valid, bus.req_ready}, 32'b110);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;
        chk("hold.release", {29'd0, bus.busy, bus.resp_valid, bus.req_ready}, 32'b001);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        chk("hold.next_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("hold.next_result", bus.result, 32'hFFFF_FFFF);
        bus.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;

        // Kill at CALC count=10: no response, result keeps its last value.
        @(negedge clock);
        drive_req(3'd5, 32'd100, 32'd7);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        repeat (10) begin
            @(posedge clock); #1;
        end
        bus.kill = 1'b1;
        @(posedge clock); #1;
        bus.kill = 1'b0;
        chk("kill.flags", {29'd0, bus.busy, bus.resp_valid, bus.req_ready}, 32'b001);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.resp_valid === 1'b1) seen = 1'b1;
        end
        chk("kill.no_resp", {31'd0, seen}, 32'd0);
        chk("kill.result_held", bus.result, 32'hFFFF_FFFF);

        // A request presented together with kill is ignored.
        @(negedge clock);
        drive_req(3'd5, 32'd5, 32'd0);
        bus.kill = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.kill      = 1'b0;
        chk("kill.req_ignored", {30'd0, bus.busy, bus.resp_valid}, 32'b00);

        // Asynchronous reset mid-CALC.
        @(negedge clock);
        drive_req(3'd5, 32'd100, 32'd7);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        #1;
        chk("arst.flags", {29'd0, bus.busy, bus.resp_valid, bus.req_ready}, 32'b001);
        chk("arst.result", bus.result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op("post_rst_div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
